// File: rtl/line_streamer_pkg.sv
// Shared state encoding, default widths and pointer-entry layout for line_streamer.
package line_streamer_pkg;
  localparam int DEF_CHAR_W = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 10;
  localparam int DEF_LINE_W = 8;

  // Pointer entry is {len, start}; start sits at the bottom, len directly above it.
  localparam int PTR_START_LSB = 0;

  typedef enum logic [2:0] {
    IDLE, PTR_WAIT, PTR_LAT, CH_RD, CH_CAP, CH_OUT, DONE
  } state_t;
endpackage

// File: rtl/pair_out_reg.sv
// Output character-pair register; holds valid and data until the consumer takes them.
module pair_out_reg
  import line_streamer_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [CHAR_W-1:0] load_lhs,
  input  logic [CHAR_W-1:0] load_rhs,
  input  logic              load_last,
  output logic              valid,
  output logic              last,
  output logic [CHAR_W-1:0] lhs,
  output logic [CHAR_W-1:0] rhs,
  output logic              fire
);
  assign fire = valid & ready;

  // flush outranks load so an abort landing in CH_CAP never exposes a pair
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
      lhs   <= '0;
      rhs   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
      lhs   <= load_lhs;
      rhs   <= load_rhs;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/line_streamer.sv
// Streams one line of character pairs: pointer-table lookup, then sequential pair reads.
module line_streamer
  import line_streamer_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LINE_W-1:0]       req_line,
  input  logic                    abort,
  output logic [LINE_W-1:0]       ptr_addr,
  input  logic [LEN_W+ADDR_W-1:0] ptr_dout,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [2*CHAR_W-1:0]     mem_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHAR_W-1:0]       out_lhs,
  output logic [CHAR_W-1:0]       out_rhs,
  output logic                    out_last,
  output logic                    done,
  output logic                    busy
);
  localparam int LEN_LSB = PTR_START_LSB + ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] ptr_start;
  logic [LEN_W-1:0]  ptr_len;
  logic              fire;

  assign ptr_start = ptr_dout[PTR_START_LSB +: ADDR_W];
  assign ptr_len   = ptr_dout[LEN_LSB +: LEN_W];
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // abort in IDLE simply holds IDLE, which also blocks any pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr_addr  <= '0;
      mem_addr  <= '1;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            ptr_addr <= req_line;
            state    <= PTR_WAIT;
          end
          PTR_WAIT: state <= PTR_LAT;
          PTR_LAT: if (ptr_len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            mem_addr  <= ptr_start;
            remaining <= ptr_len;
            state     <= CH_RD;
          end
          CH_RD:  state <= CH_CAP;
          CH_CAP: state <= CH_OUT;
          CH_OUT: if (fire) begin
            // <= rather than == keeps remaining from ever wrapping below zero
            if (remaining <= LEN_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              mem_addr  <= mem_addr + ADDR_ONE;
              remaining <= remaining - LEN_ONE;
              state     <= CH_RD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  pair_out_reg #(.CHAR_W(CHAR_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (state == CH_CAP),
    .flush     (abort && (state != IDLE)),
    .ready     (out_ready),
    .load_lhs  (mem_dout[2*CHAR_W-1:CHAR_W]),
    .load_rhs  (mem_dout[CHAR_W-1:0]),
    .load_last (remaining == LEN_ONE),
    .valid     (out_valid),
    .last      (out_last),
    .lhs       (out_lhs),
    .rhs       (out_rhs),
    .fire      (fire)
  );
endmodule

// File: tb/tb_line_streamer.sv
// Bench for line_streamer: vector table, hand-written corner sequences, randomized lines.
module tb_line_streamer;
  localparam int CHAR_W = 8, ADDR_W = 10, LEN_W = 10, LINE_W = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic req_ready, out_valid, out_last, done, busy;
  logic [LINE_W-1:0] req_line = '0, ptr_addr;
  logic [LEN_W+ADDR_W-1:0] ptr_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [2*CHAR_W-1:0] mem_dout;
  logic [CHAR_W-1:0] out_lhs, out_rhs;

  logic [LEN_W+ADDR_W-1:0] ptr_mem [2**LINE_W];
  int vectors = 0, errors = 0;

  line_streamer #(.CHAR_W(CHAR_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
    .abort(abort), .ptr_addr(ptr_addr), .ptr_dout(ptr_dout), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready), .out_lhs(out_lhs),
    .out_rhs(out_rhs), .out_last(out_last), .done(done), .busy(busy));

  always #5 clk = ~clk;

  // Character contents as a function of address: both halves together identify the address.
  function automatic logic [2*CHAR_W-1:0] chr(input logic [ADDR_W-1:0] a);
    logic [7:0] rhs;
    rhs = {a[9:8], a[5:0]} ^ 8'h3C;
    return {a[7:0] ^ 8'hA5, rhs};
  endfunction

  function automatic logic [LEN_W+ADDR_W-1:0] make_ptr(input int len, input int start);
    logic [LEN_W-1:0]  l;
    logic [ADDR_W-1:0] s;
    l = len[LEN_W-1:0];
    s = start[ADDR_W-1:0];
    return {l, s};
  endfunction

  always @(posedge clk) begin
    ptr_dout <= ptr_mem[ptr_addr];
    mem_dout <= chr(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [CHAR_W-1:0] lhs;
    logic [CHAR_W-1:0] rhs;
    logic              last;
  } pair_t;

  pair_t             got[$];
  logic [ADDR_W-1:0] got_addr[$];
  int                dones = 0;
  pair_t             prev_pair;
  logic              prev_hold = 1'b0;

  // Observe handshakes mid-cycle; a stalled pair must not move before it is taken.
  always @(negedge clk) begin
    if (prev_hold)
      check("hold_stable", {out_valid, out_lhs, out_rhs, out_last}, {1'b1, prev_pair});
    prev_hold = !rst && !abort && out_valid && !out_ready;
    prev_pair = '{out_lhs, out_rhs, out_last};
    if (!rst && out_valid && out_ready) begin
      got.push_back('{out_lhs, out_rhs, out_last});
      got_addr.push_back(mem_addr);
    end
    if (done === 1'b1) dones++;
  end

  task automatic clear_obs();
    got.delete();
    got_addr.delete();
    dones = 0;
  endtask

  // Reference: a line is len pairs from start, start+1, ... modulo 2^ADDR_W, last on the final one.
  task automatic check_pairs(input string tag, input int line);
    int n;
    logic [ADDR_W-1:0] a;
    n = int'(ptr_mem[line][LEN_W+ADDR_W-1:ADDR_W]);
    a = ptr_mem[line][ADDR_W-1:0];
    check({tag, "_npairs"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) begin
      check({tag, "_addr"}, got_addr[i], a);
      check({tag, "_pair"}, got[i], {chr(a), i == n - 1});
      a++;
    end
    check({tag, "_done_count"}, dones, 1);
  endtask

  // mode 0: out_ready always high; mode 1: random out_ready.
  task automatic run_line(input int line, input int mode, output int fv, output int dn);
    clear_obs();
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk) #1;
    req_line = line[LINE_W-1:0];
    req_valid = 1'b1;
    fv = -1;
    dn = -1;
    for (int k = 1; k <= 400 && dn < 0; k++) begin
      @(posedge clk) #1;
      req_valid = 1'b0;
      if (out_valid && fv < 0) fv = k;
      if (done) dn = k;
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    @(posedge clk) #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    out_ready = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 50 && !out_valid; k++) @(posedge clk) #1;
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 100 && !done; k++) @(posedge clk) #1;
    check({tag, "_done"}, done, 1);
    @(posedge clk) #1;
  endtask

  typedef struct {
    int line;
    int len;
    int start;
    int exp_fv;
    int exp_dn;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int fv, dn;
    for (int i = 0; i < 2**LINE_W; i++) ptr_mem[i] = '0;

    // first valid is the 5th edge counting the accept edge; done lands at edge 3*len+3
    tbl[0] = '{3, 4, 'h010, 5, 15};
    tbl[1] = '{7, 0, 'h020, -1, 3};
    tbl[2] = '{9, 1, 'h100, 5, 6};
    tbl[3] = '{12, 3, 'h3FF, 5, 12};
    tbl[4] = '{20, 2, 'h200, 5, 9};
    for (int i = 0; i < 5; i++) ptr_mem[tbl[i].line] = make_ptr(tbl[i].len, tbl[i].start);
    ptr_mem[40] = make_ptr(3, 'h050);
    ptr_mem[41] = make_ptr(5, 'h0A0);
    ptr_mem[42] = make_ptr(2, 'h0C0);
    ptr_mem[43] = make_ptr(3, 'h300);

    // reset with a request pending
    rst = 1'b1; req_valid = 1'b1; req_line = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", {out_lhs, out_rhs}, 0);
    check("rst_ptr_addr", ptr_addr, 0);
    check("rst_mem_addr", mem_addr, 'h3FF);
    rst = 1'b0; req_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_line(tbl[i].line, 0, fv, dn);
      check("tbl_first_valid", fv, tbl[i].exp_fv);
      check("tbl_done_edge", dn, tbl[i].exp_dn);
      check_pairs("tbl", tbl[i].line);
    end

    // stall the second pair for 7 cycles
    clear_obs();
    out_ready = 1'b0;
    @(posedge clk) #1; req_line = 8'd40; req_valid = 1'b1;
    @(posedge clk) #1; req_valid = 1'b0;
    wait_valid("stall1");
    out_ready = 1'b1;
    @(posedge clk) #1; out_ready = 1'b0;
    wait_valid("stall2");
    for (int i = 0; i < 7; i++) begin
      @(posedge clk) #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", {out_lhs, out_rhs}, chr(10'h051));
      check("stall_addr", mem_addr, 'h051);
    end
    out_ready = 1'b1;
    wait_done("stall");
    check_pairs("stall", 40);

    // abort during the second CH_OUT of a 5-pair line
    clear_obs();
    out_ready = 1'b0;
    @(posedge clk) #1; req_line = 8'd41; req_valid = 1'b1;
    @(posedge clk) #1; req_valid = 1'b0;
    wait_valid("abort1");
    out_ready = 1'b1;
    @(posedge clk) #1; out_ready = 1'b0;
    wait_valid("abort2");
    abort = 1'b1;
    @(posedge clk) #1; abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_last", out_last, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", dones, 0);
    check("abort_pairs", got.size(), 1);
    run_line(3, 0, fv, dn);
    check("post_abort_first_valid", fv, 5);
    check_pairs("post_abort", 3);

    // abort coinciding with a handshake: the pair is delivered, done stays low
    clear_obs();
    out_ready = 1'b1;
    @(posedge clk) #1; req_line = 8'd42; req_valid = 1'b1;
    @(posedge clk) #1; req_valid = 1'b0;
    wait_valid("abort_hs");
    abort = 1'b1;
    @(posedge clk) #1; abort = 1'b0;
    check("abort_hs_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_hs_pairs", got.size(), 1);
    if (got.size() >= 1) check("abort_hs_pair0", got[0], {chr(10'h0C0), 1'b0});
    check("abort_hs_no_done", dones, 0);

    // abort in IDLE blocks a pending request
    abort = 1'b1; req_valid = 1'b1; req_line = 8'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      check("idle_abort_busy", busy, 0);
    end
    abort = 1'b0; req_valid = 1'b0;

    // reset during CH_CAP, request held through reset
    clear_obs();
    out_ready = 1'b1;
    @(posedge clk) #1; req_line = 8'd43; req_valid = 1'b1;
    @(posedge clk) #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cap_busy", busy, 1);
    check("cap_no_valid", out_valid, 0);
    rst = 1'b1; req_valid = 1'b1;
    @(posedge clk) #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", {out_lhs, out_rhs, out_last}, 0);
    check("midrst_mem_addr", mem_addr, 'h3FF);
    check("midrst_ptr_addr", ptr_addr, 0);
    check("midrst_done", done, 0);
    repeat (2) begin
      @(posedge clk) #1;
      check("midrst_hold_busy", busy, 0);
    end
    clear_obs();
    rst = 1'b0;
    check("postrst_req_ready", req_ready, 1);
    @(posedge clk) #1;
    req_valid = 1'b0;
    check("postrst_accept", busy, 1);
    wait_done("postrst");
    check_pairs("postrst", 43);

    // randomized lines with random backpressure
    for (int i = 0; i < 40; i++) begin
      ptr_mem[50 + i] = make_ptr($urandom_range(0, 9), $urandom_range(0, 1023));
      run_line(50 + i, 1, fv, dn);
      check_pairs("rand", 50 + i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/line_streamer.md
LINE_STREAMER -- requirements
Module: line_streamer

Interface
REQ-001 Parameter CHAR_W, default 8, width of one character.
REQ-002 Parameter ADDR_W, default 10, character-memory address width.
REQ-003 Parameter LEN_W, default 10, line-length field width.
REQ-004 Parameter LINE_W, default 8, line-index width and pointer-table address width.
REQ-005 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  request to stream one line.
REQ-008 req_ready  out  1  SHALL be high exactly when the state is IDLE.
REQ-009 req_line  in  LINE_W  line index, sampled on the req handshake.
REQ-010 abort  in  1  cancels the line in progress.
REQ-011 ptr_addr  out  LINE_W  pointer-table read address, registered.
REQ-012 ptr_dout  in  LEN_W+ADDR_W  pointer entry: {len, start}, with start in the low ADDR_W bits.
REQ-013 mem_addr  out  ADDR_W  character-memory read address, registered.
REQ-014 mem_dout  in  2*CHAR_W  {lhs, rhs} character pair.
REQ-015 out_valid / out_ready  out / in  1 / 1  output stream handshake.
REQ-016 out_lhs, out_rhs  out  CHAR_W each  registered character pair.
REQ-017 out_last  out  1  marks the final pair of a line.
REQ-018 done  out  1  one-cycle pulse after the last pair is accepted, or after a zero-length line.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 Both memories SHALL be treated as synchronous-read: dout is valid in the cycle after the edge that samples the address.
REQ-021 States SHALL be IDLE, PTR_WAIT, PTR_LAT, CH_RD, CH_CAP, CH_OUT, DONE.
REQ-022 IDLE: on req_valid, ptr_addr <= req_line, then go to PTR_WAIT.
REQ-023 PTR_WAIT: unconditional move to PTR_LAT.
REQ-024 PTR_LAT: latch start and len from ptr_dout.
  - len==0: go to DONE.
  - otherwise: mem_addr <= start, remaining <= len, go to CH_RD.
REQ-025 CH_RD: go to CH_CAP; mem_addr SHALL be held stable.
REQ-026 CH_CAP: out_lhs/out_rhs <= mem_dout, out_valid <= 1, out_last <= (remaining==1), go to CH_OUT.
REQ-027 CH_OUT: hold out_valid and all out_* stable until out_ready.
  - On handshake, out_valid <= 0.
  - If remaining==1, go to DONE.
  - Otherwise mem_addr <= mem_addr+1, remaining <= remaining-1, go to CH_RD.
REQ-028 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-029 mem_addr increment SHALL wrap modulo 2^ADDR_W; remaining SHALL never underflow.
REQ-030 Throughput SHALL be one pair per 3 cycles with out_ready held high.
REQ-031 Request-to-first-out_valid latency SHALL be 5 cycles: accept edge, PTR_WAIT, PTR_LAT, CH_RD, CH_CAP.
REQ-032 abort in any non-IDLE state SHALL force IDLE at the next edge.
  - out_valid and out_last SHALL clear at that edge.
  - done SHALL NOT pulse.
REQ-033 abort has priority over every other transition; abort in IDLE has no effect, and any request pending while abort is high SHALL NOT be accepted.
REQ-034 An abort asserted in the same cycle as an out handshake SHALL still take priority; that pair counts as delivered, but done SHALL NOT pulse.
REQ-035 req_valid outside IDLE SHALL be ignored.

Reset
REQ-036 rst SHALL put the block in IDLE, with precedence over abort and req_valid.
REQ-037 Reset values SHALL be:
  - ptr_addr=0, mem_addr=all-ones, remaining=0.
  - out_valid=0, out_last=0, out_lhs=0, out_rhs=0.
  - done=0, busy=0.
REQ-038 Reset mid-line SHALL discard the line with no done pulse; req_ready SHALL be high in the first cycle after rst drops.

Structure
REQ-039 A shared package SHALL hold:
  - the state enumeration;
  - default parameter constants;
  - the ptr_dout field-slicing widths.
REQ-040 The output register with its valid/ready hold SHALL be one sub-module, pair_out_reg; all remaining logic SHALL stay flat.

Verification
REQ-041 Entry line 3 = {len=4, start=0x010}, out_ready=1 -> pairs from 0x010..0x013 in order, out_last on the 4th only, done one cycle after the 4th handshake, first out_valid 5 cycles after accept.
REQ-042 Entry {len=0, start=0x020} -> no out_valid, done exactly 3 cycles after accept.
REQ-043 Entry {len=3, start=0x3FF}, ADDR_W=10 -> mem_addr sequence 0x3FF, 0x000, 0x001.
REQ-044 out_ready held low for 7 cycles on the 2nd pair -> out_lhs/out_rhs/out_valid stable throughout, mem_addr unchanged, no pair lost or duplicated.
REQ-045 abort during the 2nd CH_OUT of a 5-pair line -> IDLE next cycle, out_valid=0, no done; a following request streams correctly.
REQ-046 rst during CH_CAP -> all reset values next cycle; req_valid held high during rst is not accepted until rst drops.
